// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU codes, sequencer states and the strobe bundle shared by the control unit
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    typedef enum logic [3:0] {
        RESET, T0, T1, T2, T3, T4, T5, T6, T7, PAUSE, HALT
    } state_t;

    typedef struct packed {
        logic gra, grb, grc, rin, rout, ba_out;
        logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write, ir_in;
        logic y_in, z_in, zhigh_out, zlow_out, hi_in, lo_in, hi_out, lo_out;
        logic c_out, con_in, inport_out, outport_in;
        logic [4:0] alu_op;
    } ctrl_t;

    function automatic logic is_alu_reg(input logic [4:0] op);
        return op >= OP_ADD && op <= OP_OR;
    endfunction

    function automatic logic is_alu_imm(input logic [4:0] op);
        return op >= OP_ADDI && op <= OP_ORI;
    endfunction

    // Final execute step of each instruction; anything unlisted behaves as nop and ends after fetch.
    function automatic state_t last_step(input logic [4:0] op);
        return (op == OP_LD || op == OP_ST) ? T7 :
               (op == OP_MUL || op == OP_DIV || op == OP_BR) ? T6 :
               (is_alu_reg(op) || is_alu_imm(op) || op == OP_LDI) ? T5 :
               (op == OP_NEG || op == OP_NOT) ? T4 :
               (op inside {OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_HALT}) ? T3 : T2;
    endfunction

endpackage

// File: rtl/ctrl_step_decode.sv
// ctrl_step_decode: combinational (state, opcode, CON) to strobe-vector decode
module ctrl_step_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] op,
    input  logic       con,
    output ctrl_t      c
);

    logic alu_r, alu_i, neg_not, mul_div, mem;

    assign alu_r   = is_alu_reg(op);
    assign alu_i   = is_alu_imm(op);
    assign neg_not = op == OP_NEG || op == OP_NOT;
    assign mul_div = op == OP_MUL || op == OP_DIV;
    assign mem     = op == OP_LD || op == OP_LDI || op == OP_ST;

    // Fetch steps ignore the opcode; execute steps decode it from T3 on.
    always_comb begin
        c = '0;
        case (state)
            T0: begin
                c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
            end
            T1: begin
                c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
            end
            T2: begin
                c.mdr_out = 1'b1; c.ir_in = 1'b1;
            end
            T3: begin
                if (alu_r || alu_i) begin
                    c.grb = 1'b1; c.rout = 1'b1; c.y_in = 1'b1;
                end else if (neg_not) begin
                    c.grb = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; c.alu_op = op;
                end else if (mul_div) begin
                    c.gra = 1'b1; c.rout = 1'b1; c.y_in = 1'b1;
                end else if (mem) begin
                    c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
                end else if (op == OP_BR) begin
                    c.gra = 1'b1; c.rout = 1'b1; c.con_in = 1'b1;
                end else if (op == OP_JR) begin
                    c.gra = 1'b1; c.rout = 1'b1; c.pc_in = 1'b1;
                end else if (op == OP_IN) begin
                    c.gra = 1'b1; c.rin = 1'b1; c.inport_out = 1'b1;
                end else if (op == OP_OUT) begin
                    c.gra = 1'b1; c.rout = 1'b1; c.outport_in = 1'b1;
                end else if (op == OP_MFHI || op == OP_MFLO) begin
                    c.gra = 1'b1; c.rin = 1'b1; c.hi_out = op == OP_MFHI; c.lo_out = op == OP_MFLO;
                end
            end
            T4: begin
                if (alu_r) begin
                    c.grc = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; c.alu_op = op;
                end else if (alu_i) begin
                    c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = op;
                end else if (neg_not) begin
                    c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
                end else if (mul_div) begin
                    c.grb = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; c.alu_op = op;
                end else if (mem) begin
                    c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = ALU_ADD;
                end else if (op == OP_BR) begin
                    c.pc_out = 1'b1; c.y_in = 1'b1;
                end
            end
            T5: begin
                if (alu_r || alu_i || op == OP_LDI) begin
                    c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
                end else if (mul_div) begin
                    c.zlow_out = 1'b1; c.lo_in = 1'b1;
                end else if (op == OP_LD || op == OP_ST) begin
                    c.zlow_out = 1'b1; c.mar_in = 1'b1;
                end else if (op == OP_BR) begin
                    c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = ALU_ADD;
                end
            end
            T6: begin
                if (mul_div) begin
                    c.zhigh_out = 1'b1; c.hi_in = 1'b1;
                end else if (op == OP_LD) begin
                    c.read = 1'b1; c.mdr_in = 1'b1;
                end else if (op == OP_ST) begin
                    c.gra = 1'b1; c.rout = 1'b1; c.mdr_in = 1'b1;
                end else if (op == OP_BR) begin
                    c.zlow_out = 1'b1; c.pc_in = con;
                end
            end
            T7: begin
                if (op == OP_LD) begin
                    c.mdr_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
                end else if (op == OP_ST) begin
                    c.write = 1'b1;
                end
            end
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle instruction sequencer driving datapath strobes from state and opcode
module control_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stop,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout,
    output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
    output logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout,
    output logic        Cout, CONin, InPortout, OutPortin,
    output logic [4:0]  alu_op,
    output logic        Run
);

    state_t     state, nxt;
    ctrl_t      c;
    logic [4:0] op;
    logic       unused_ir;

    assign op        = IR[31:27];
    assign unused_ir = ^IR[26:0];

    // State register; reset abandons any partial instruction immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RESET;
        else state <= nxt;
    end

    // Step sequencing; the opcode only matters at T2 (nop ends there) and later.
    always_comb begin
        nxt = state;
        case (state)
            RESET:   nxt = T0;
            PAUSE:   nxt = stop ? PAUSE : T0;
            HALT:    nxt = HALT;
            default: nxt = (state == T3 && op == OP_HALT) ? HALT :
                           (state == last_step(op)) ? (stop ? PAUSE : T0) :
                           state_t'(state + 4'd1);
        endcase
    end

    ctrl_step_decode u_dec (.state(state), .op(op), .con(CON), .c(c));

    assign {Gra, Grb, Grc, Rin, Rout, BAout} = {c.gra, c.grb, c.grc, c.rin, c.rout, c.ba_out};
    assign {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin} =
           {c.pc_out, c.pc_in, c.inc_pc, c.mar_in, c.mdr_in, c.mdr_out, c.read, c.write, c.ir_in};
    assign {Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout} =
           {c.y_in, c.z_in, c.zhigh_out, c.zlow_out, c.hi_in, c.lo_in, c.hi_out, c.lo_out};
    assign {Cout, CONin, InPortout, OutPortin} = {c.c_out, c.con_in, c.inport_out, c.outport_in};
    assign alu_op = c.alu_op;
    assign Run    = !(state inside {RESET, PAUSE, HALT});

endmodule
